// File: rtl/alu_cmd_sequencer.sv
// Operator front end for the 3-bit ALU: builds {op,a,b} from switches over three
// debounced key presses, strobes it to the ALU and captures the result.
module alu_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_LATENCY     = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] sw_i,
    input  logic       key_step_n_i,
    input  logic       key_clr_n_i,
    input  logic [2:0] alu_z_i,
    input  logic       alu_ovf_i,
    input  logic       alu_err_i,
    output logic [8:0] alu_cmd_o,
    output logic       cmd_valid_o,
    output logic [2:0] res_z_o,
    output logic       res_ovf_o,
    output logic       res_err_o,
    output logic       res_valid_o,
    output logic [2:0] state_o
);

    // state    | meaning
    // ENTER_A  | waiting for step to latch operand A from switches
    // ENTER_B  | waiting for step to latch operand B
    // ENTER_OP | waiting for step to latch opcode and launch the command
    // ISSUE    | command presented to ALU for ALU_LATENCY cycles
    // SHOW     | result held for display until next step
    typedef enum logic [2:0] {
        S_ENTER_A  = 3'd0,
        S_ENTER_B  = 3'd1,
        S_ENTER_OP = 3'd2,
        S_ISSUE    = 3'd3,
        S_SHOW     = 3'd4
    } state_t;

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW  = $clog2(ALU_LATENCY + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0]  LAT_LOAD = LW'(ALU_LATENCY - 1);

    // Key index 0 = step, 1 = clear; all key-path flops reset to the released level.
    logic [1:0]     key_raw;
    logic [1:0]     sync1_q, sync2_q, level_q, level_d, prev_q, press;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];
    logic           step_p, clr_p;

    state_t     state_q, state_d;
    logic [2:0] a_q, a_d, b_q, b_d, op_q, op_d, res_z_q, res_z_d;
    logic       res_ovf_q, res_ovf_d, res_err_q, res_err_d, res_valid_q, res_valid_d;
    logic [LW-1:0] lat_q, lat_d;

    assign key_raw = {key_clr_n_i, key_step_n_i};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            level_d[k]  = level_q[k];
            db_cnt_d[k] = '0;
            if (sync2_q[k] != level_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) level_d[k] = sync2_q[k];
                else                        db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
            end
        end
    end

    assign press  = prev_q & ~level_q;
    assign clr_p  = press[1];
    assign step_p = press[0] & ~press[1];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_z_d     = res_z_q;
        res_ovf_d   = res_ovf_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        lat_d       = lat_q;
        if (clr_p) begin
            state_d     = S_ENTER_A;
            a_d         = '0;
            b_d         = '0;
            op_d        = '0;
            res_z_d     = '0;
            res_ovf_d   = 1'b0;
            res_err_d   = 1'b0;
            res_valid_d = 1'b0;
            lat_d       = '0;
        end else begin
            case (state_q)
                S_ENTER_A: if (step_p) begin
                    a_d     = sw_i;
                    state_d = S_ENTER_B;
                end
                S_ENTER_B: if (step_p) begin
                    b_d     = sw_i;
                    state_d = S_ENTER_OP;
                end
                S_ENTER_OP: if (step_p) begin
                    op_d        = sw_i;
                    res_valid_d = 1'b0;
                    lat_d       = LAT_LOAD;
                    state_d     = S_ISSUE;
                end
                S_ISSUE: begin
                    if (lat_q == '0) begin
                        res_z_d     = alu_z_i;
                        res_ovf_d   = alu_ovf_i;
                        res_err_d   = alu_err_i;
                        res_valid_d = 1'b1;
                        state_d     = S_SHOW;
                    end else begin
                        lat_d = lat_q - LW'(1);
                    end
                end
                S_SHOW: if (step_p) state_d = S_ENTER_A;
                default: state_d = S_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            level_q     <= 2'b11;
            prev_q      <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= S_ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_z_q     <= '0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            lat_q       <= '0;
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            prev_q      <= level_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_z_q     <= res_z_d;
            res_ovf_q   <= res_ovf_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            lat_q       <= lat_d;
        end
    end

    assign alu_cmd_o   = {op_q, a_q, b_q};
    assign cmd_valid_o = (state_q == S_ISSUE);
    assign res_z_o     = res_z_q;
    assign res_ovf_o   = res_ovf_q;
    assign res_err_o   = res_err_q;
    assign res_valid_o = res_valid_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed table, corner sequences,
// and random key sequences against a field-level operator model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'd0;
    logic       key_step_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic [2:0] alu_z;
    logic       alu_ovf, alu_err;
    logic [8:0] alu_cmd;
    logic       cmd_valid;
    logic [2:0] res_z;
    logic       res_ovf, res_err, res_valid;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;
    int cv_cnt  = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LATENCY(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw),
        .key_step_n_i(key_step_n), .key_clr_n_i(key_clr_n),
        .alu_z_i(alu_z), .alu_ovf_i(alu_ovf), .alu_err_i(alu_err),
        .alu_cmd_o(alu_cmd), .cmd_valid_o(cmd_valid),
        .res_z_o(res_z), .res_ovf_o(res_ovf), .res_err_o(res_err),
        .res_valid_o(res_valid), .state_o(state)
    );

    // Behavioural ALU: returns {z, ovf, err}; 3-bit signed add/sub, ops 5-7 illegal.
    function automatic logic [4:0] alu_model(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        int r = 0;
        logic [2:0] z = 3'd0;
        logic ovf = 1'b0;
        logic err = 1'b0;
        case (op)
            3'd0: z = a & b;
            3'd1: z = a | b;
            3'd2: z = a ^ b;
            3'd3: begin r = sa + sb; z = r[2:0]; ovf = (r > 3) || (r < -4); end
            3'd4: begin r = sa - sb; z = r[2:0]; ovf = (r > 3) || (r < -4); end
            default: err = 1'b1;
        endcase
        return {z, ovf, err};
    endfunction

    assign {alu_z, alu_ovf, alu_err} = alu_model(alu_cmd[8:6], alu_cmd[5:3], alu_cmd[2:0]);

    always @(negedge clk) if (cmd_valid === 1'b1) cv_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_press(input bit clr, input logic [2:0] v);
        @(negedge clk);
        sw = v;
        if (clr) key_clr_n = 1'b0;
        else     key_step_n = 1'b0;
        repeat (12) @(negedge clk);
        key_clr_n  = 1'b1;
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    typedef struct {
        bit         clr;
        logic [2:0] sw;
        logic [2:0] st;
        logic [8:0] cmd;
        logic [2:0] z;
        logic       ovf;
        logic       err;
        logic       rv;
    } vec_t;

    vec_t vecs[14];

    // Operator-level reference model state
    int         m_st;
    logic [2:0] m_a, m_b, m_op, m_z;
    logic       m_ovf, m_err, m_rv;

    initial begin
        int cv0;
        logic [4:0] r;
        vecs[0]  = '{0, 3'd1, 3'd1, 9'b000_001_000, 3'd0, 0, 0, 0};
        vecs[1]  = '{0, 3'd1, 3'd2, 9'b000_001_001, 3'd0, 0, 0, 0};
        vecs[2]  = '{0, 3'd3, 3'd4, 9'b011_001_001, 3'b010, 0, 0, 1};
        vecs[3]  = '{0, 3'd5, 3'd0, 9'b011_001_001, 3'b010, 0, 0, 1};
        vecs[4]  = '{0, 3'd3, 3'd1, 9'b011_011_001, 3'b010, 0, 0, 1};
        vecs[5]  = '{0, 3'd4, 3'd2, 9'b011_011_100, 3'b010, 0, 0, 1};
        vecs[6]  = '{0, 3'd4, 3'd4, 9'b100_011_100, 3'b111, 1, 0, 1};
        vecs[7]  = '{0, 3'd0, 3'd0, 9'b100_011_100, 3'b111, 1, 0, 1};
        vecs[8]  = '{0, 3'd2, 3'd1, 9'b100_010_100, 3'b111, 1, 0, 1};
        vecs[9]  = '{0, 3'd1, 3'd2, 9'b100_010_001, 3'b111, 1, 0, 1};
        vecs[10] = '{0, 3'd6, 3'd4, 9'b110_010_001, 3'b000, 0, 1, 1};
        vecs[11] = '{1, 3'd0, 3'd0, 9'b000_000_000, 3'b000, 0, 0, 0};
        vecs[12] = '{0, 3'd7, 3'd1, 9'b000_111_000, 3'b000, 0, 0, 0};
        vecs[13] = '{1, 3'd0, 3'd0, 9'b000_000_000, 3'b000, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_cmd", 32'(alu_cmd), 0);
        chk("rst_cv", 32'(cmd_valid), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            cv0 = cv_cnt;
            do_press(vecs[i].clr, vecs[i].sw);
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_cmd", i), 32'(alu_cmd), 32'(vecs[i].cmd));
            chk($sformatf("v%0d_res", i), 32'({res_z, res_ovf, res_err, res_valid}),
                32'({vecs[i].z, vecs[i].ovf, vecs[i].err, vecs[i].rv}));
            chk($sformatf("v%0d_cvcycles", i), 32'(cv_cnt - cv0), (vecs[i].st == 3'd4) ? 32'd2 : 32'd0);
        end

        // Asynchronous reset in the middle of ISSUE
        do_press(0, 3'd5);
        do_press(0, 3'd2);
        @(negedge clk);
        sw = 3'd4;
        key_step_n = 1'b0;
        wait_state(3'd3, 30, "reach_issue_rst");
        chk("cv_before_rst", 32'(cmd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'({alu_cmd, cmd_valid, res_z, res_ovf, res_err, res_valid}), 0);
        chk("arst_state", 32'(state), 0);
        key_step_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_state", 32'(state), 0);

        // Bouncing key: only the final settled press advances
        sw = 3'd5;
        for (int i = 0; i < 10; i++) begin
            key_step_n = ~key_step_n;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_adv", 32'(state), 0);
        key_step_n = 1'b0;
        repeat (50) @(negedge clk);
        chk("bounce_one_adv", 32'(state), 1);
        chk("bounce_a", 32'(alu_cmd), 32'(9'b000_101_000));
        repeat (1000) @(negedge clk);
        chk("held_one_adv", 32'(state), 1);
        key_step_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("release_no_adv", 32'(state), 1);

        // Clear and step together in ENTER_B
        @(negedge clk);
        sw = 3'd2;
        key_step_n = 1'b0;
        key_clr_n  = 1'b0;
        repeat (12) @(negedge clk);
        key_step_n = 1'b1;
        key_clr_n  = 1'b1;
        repeat (12) @(negedge clk);
        chk("clr_step_state", 32'(state), 0);
        chk("clr_step_cmd", 32'(alu_cmd), 0);

        // ISSUE lasts exactly ALU_LATENCY cycles, with the held step key ignored
        do_press(0, 3'd2);
        do_press(0, 3'd3);
        @(negedge clk);
        sw = 3'd0;
        key_step_n = 1'b0;
        wait_state(3'd3, 30, "reach_issue");
        chk("issue_cmd", 32'(alu_cmd), 32'(9'b000_010_011));
        @(negedge clk);
        chk("issue_cycle2", 32'(state), 3);
        @(negedge clk);
        chk("issue_to_show", 32'(state), 4);
        chk("and_res", 32'({res_z, res_valid}), 32'({3'b010, 1'b1}));
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);

        // SHOW + step keeps the result; next opcode entry drops RES_VALID
        do_press(0, 3'd7);
        chk("show_step_state", 32'(state), 0);
        chk("show_step_res", 32'({res_z, res_valid}), 32'({3'b010, 1'b1}));
        do_press(0, 3'd1);
        do_press(0, 3'd1);
        chk("hold_res_in_op", 32'(res_valid), 1);
        @(negedge clk);
        sw = 3'd3;
        key_step_n = 1'b0;
        wait_state(3'd3, 30, "reach_issue2");
        chk("rv_cleared_issue", 32'(res_valid), 0);
        key_step_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("add_again", 32'({res_z, res_ovf, res_err, res_valid}), 32'({3'b010, 1'b0, 1'b0, 1'b1}));

        // Random operator sequences against the field-level model
        do_press(1, 3'd0);
        m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_z = 0; m_ovf = 0; m_err = 0; m_rv = 0;
        for (int i = 0; i < 150; i++) begin
            bit c;
            logic [2:0] v;
            int exp_cv;
            c = ($urandom_range(0, 7) == 0);
            v = 3'($urandom_range(0, 7));
            exp_cv = 0;
            if (c) begin
                m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_z = 0; m_ovf = 0; m_err = 0; m_rv = 0;
            end else if (m_st == 0) begin
                m_a = v; m_st = 1;
            end else if (m_st == 1) begin
                m_b = v; m_st = 2;
            end else if (m_st == 2) begin
                m_op = v;
                r = alu_model(m_op, m_a, m_b);
                {m_z, m_ovf, m_err} = r;
                m_rv = 1'b1;
                m_st = 4;
                exp_cv = 2;
            end else begin
                m_st = 0;
            end
            cv0 = cv_cnt;
            do_press(c, v);
            chk($sformatf("r%0d_state", i), 32'(state), 32'(m_st));
            chk($sformatf("r%0d_cmd", i), 32'(alu_cmd), 32'({m_op, m_a, m_b}));
            chk($sformatf("r%0d_res", i), 32'({res_z, res_ovf, res_err, res_valid}),
                32'({m_z, m_ovf, m_err, m_rv}));
            chk($sformatf("r%0d_cv", i), 32'(cv_cnt - cv0), 32'(exp_cv));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
